// File: rtl/edge_event_arbiter.sv
// Edge detector for a bank of asynchronous lines: synchronise, timestamp, round-robin
// arbitrate pending edges into a show-ahead event FIFO with a sticky lost-event flag.
module edge_event_arbiter #(
  parameter int NUM_LINES  = 4,
  parameter int EDGE_MODE  = 2,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] lines,
  input  logic                 enable,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [LW-1:0]        evt_line,
  output logic                 evt_level,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = LW + 1 + TS_WIDTH;

  logic [NUM_LINES-1:0] s0, s1, prev, pending, lvl;
  logic [NUM_LINES-1:0] rise, fall, edge_det, qual, load, drop, gnt_vec;
  logic [TS_WIDTH-1:0]  ts_lat [NUM_LINES];
  logic [TS_WIDTH-1:0]  ts_cnt;
  logic [1:0]           warm;
  logic [LW-1:0]        rr, gnt_idx;
  logic                 found, grant;
  int                   idx;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;

  // Detection waits until s0, s1 and prev all hold real line levels, so lines
  // that were already high through reset never look like an edge.
  always_comb begin
    rise = s1 & ~prev;
    fall = ~s1 & prev;
    if (EDGE_MODE == 0)      edge_det = rise;
    else if (EDGE_MODE == 1) edge_det = fall;
    else                     edge_det = rise | fall;
    qual = (enable && warm == 2'd3) ? edge_det : '0;
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_LINES; k++) begin
      idx = (int'(rr) + k) % NUM_LINES;
      if (!found && pending[idx]) begin
        found   = 1'b1;
        gnt_idx = LW'(idx);
      end
    end
    grant = found && !full;
    for (int i = 0; i < NUM_LINES; i++) gnt_vec[i] = grant && (gnt_idx == LW'(i));
    load = qual & (~pending | gnt_vec);
    drop = qual & pending & ~gnt_vec;
  end

  // A line granted in the same cycle it sees a new edge reloads instead of dropping.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s0       <= '0;
      s1       <= '0;
      prev     <= '0;
      pending  <= '0;
      lvl      <= '0;
      warm     <= '0;
      ts_cnt   <= '0;
      rr       <= LW'(NUM_LINES - 1);
      overflow <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) ts_lat[i] <= '0;
    end else begin
      s0      <= lines;
      s1      <= s0;
      prev    <= s1;
      pending <= (pending & ~gnt_vec) | qual;
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (enable) ts_cnt <= ts_cnt + 1'b1;
      if (grant) rr <= gnt_idx;
      for (int i = 0; i < NUM_LINES; i++) begin
        if (load[i]) begin
          lvl[i]    <= s1[i];
          ts_lat[i] <= ts_cnt;
        end
      end
      if (|drop)               overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = grant;
  assign pop   = !empty && evt_ready;

  // Grants already require a non-full FIFO at cycle start, so a pop never frees a slot early.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {gnt_idx, lvl[gnt_idx], ts_lat[gnt_idx]};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign evt_valid                     = !empty;
  assign {evt_line, evt_level, evt_ts} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: latency, warm-up, arbitration order,
// FIFO-full overflow, timestamp wrap/hold and asynchronous reset.
module tb_edge_event_arbiter;

  logic       sys_clk;
  logic       rst;
  logic [3:0] lines;
  logic       enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_line;
  logic       evt_level;
  logic [15:0] evt_ts;
  logic       overflow;
  logic       clear_overflow;

  logic [3:0] w_lines;
  logic       w_enable;
  logic       w_valid;
  logic       w_ready;
  logic [1:0] w_line;
  logic       w_level;
  logic [3:0] w_ts;
  logic       w_overflow;

  int compared;
  int mismatched;
  logic seen;

  edge_event_arbiter dut (
    .sys_clk(sys_clk), .rst(rst), .lines(lines), .enable(enable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_line(evt_line),
    .evt_level(evt_level), .evt_ts(evt_ts), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  edge_event_arbiter #(.TS_WIDTH(4)) dut_w (
    .sys_clk(sys_clk), .rst(rst), .lines(w_lines), .enable(w_enable),
    .evt_valid(w_valid), .evt_ready(w_ready), .evt_line(w_line),
    .evt_level(w_level), .evt_ts(w_ts), .overflow(w_overflow),
    .clear_overflow(1'b0)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Leaves the bench just after a clock edge with rst low; the next edge is edge 1.
  task automatic applyStimulus(input logic [3:0] init_lines);
    lines          = init_lines;
    w_lines        = 4'b0000;
    enable         = 1'b1;
    w_enable       = 1'b1;
    evt_ready      = 1'b0;
    w_ready        = 1'b0;
    clear_overflow = 1'b0;
    rst            = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Basic latency and reset values
    applyStimulus(4'b0000);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_ts", evt_ts, 0);
    checkOutput("rst_ovf", overflow, 0);
    tick(9);
    lines[0] = 1'b1;
    tick(3);
    checkOutput("t1_valid_e12", evt_valid, 0);
    tick(1);
    checkOutput("t1_valid_e13", evt_valid, 1);
    checkOutput("t1_line", evt_line, 0);
    checkOutput("t1_level", evt_level, 1);
    checkOutput("t1_ts", evt_ts, 11);
    evt_ready = 1'b1;
    tick(1);
    checkOutput("t1_empty", evt_valid, 0);

    // Lines high through reset give no events
    applyStimulus(4'b1111);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen = seen | evt_valid;
    end
    checkOutput("t2_no_events", seen, 0);
    checkOutput("t2_ovf", overflow, 0);

    // Round-robin order of simultaneous edges
    applyStimulus(4'b0000);
    evt_ready = 1'b1;
    tick(5);
    lines = 4'b1101;
    tick(4);
    checkOutput("t3_a_valid", evt_valid, 1);
    checkOutput("t3_a_line", evt_line, 0);
    checkOutput("t3_a_ts", evt_ts, 7);
    tick(1);
    checkOutput("t3_b_line", evt_line, 2);
    checkOutput("t3_b_ts", evt_ts, 7);
    tick(1);
    checkOutput("t3_c_line", evt_line, 3);
    checkOutput("t3_c_ts", evt_ts, 7);
    tick(1);
    checkOutput("t3_empty", evt_valid, 0);
    lines = 4'b0100;
    tick(4);
    checkOutput("t3_d_line", evt_line, 0);
    checkOutput("t3_d_level", evt_level, 0);
    checkOutput("t3_d_ts", evt_ts, 14);
    tick(1);
    checkOutput("t3_e_line", evt_line, 3);
    checkOutput("t3_e_ts", evt_ts, 14);
    tick(1);
    checkOutput("t3_empty2", evt_valid, 0);

    // FIFO full, held pending, overflow
    applyStimulus(4'b0000);
    tick(5);
    for (int t = 0; t < 10; t++) begin
      lines[1] = ~lines[1];
      tick(6);
    end
    checkOutput("t4_ovf_set", overflow, 1);
    checkOutput("t4_head_valid", evt_valid, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("t4_drain%0d_valid", i), evt_valid, 1);
      checkOutput($sformatf("t4_drain%0d_line", i), evt_line, 1);
      checkOutput($sformatf("t4_drain%0d_level", i), evt_level, (i % 2 == 0) ? 1 : 0);
      tick(1);
    end
    checkOutput("t4_drained", evt_valid, 0);
    checkOutput("t4_ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    checkOutput("t4_ovf_clear", overflow, 0);

    // Timestamp wrap and hold on the 4-bit instance
    applyStimulus(4'b0000);
    w_ready = 1'b1;
    tick(13);
    w_lines[0] = 1'b1;
    tick(3);
    w_lines[0] = 1'b0;
    tick(1);
    checkOutput("t5_a_valid", w_valid, 1);
    checkOutput("t5_a_ts", w_ts, 15);
    checkOutput("t5_a_level", w_level, 1);
    tick(3);
    checkOutput("t5_b_valid", w_valid, 1);
    checkOutput("t5_b_ts", w_ts, 2);
    checkOutput("t5_b_level", w_level, 0);
    tick(1);
    w_enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2)  w_lines[0] = 1'b1;
      if (i == 8)  w_lines[0] = 1'b0;
      tick(1);
      seen = seen | w_valid;
    end
    checkOutput("t5_disabled_no_events", seen, 0);
    w_enable   = 1'b1;
    w_lines[0] = 1'b1;
    tick(4);
    checkOutput("t5_c_valid", w_valid, 1);
    checkOutput("t5_c_ts_held", w_ts, 7);

    // Asynchronous reset with queued and pending events
    applyStimulus(4'b0000);
    tick(5);
    lines = 4'b0111;
    tick(6);
    lines = 4'b0100;
    tick(3);
    checkOutput("t6_pre_valid", evt_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_async_valid", evt_valid, 0);
    checkOutput("t6_async_ovf", overflow, 0);
    tick(2);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | evt_valid;
    end
    checkOutput("t6_no_stale", seen, 0);
    lines[3] = 1'b1;
    tick(4);
    checkOutput("t6_new_valid", evt_valid, 1);
    checkOutput("t6_new_line", evt_line, 3);
    checkOutput("t6_new_ts", evt_ts, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
